// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that fills instruction memory while holding the CPU in reset
// Frame: count byte (0 = 256), then per word a HI byte (bit 7 must be 0) and a LO byte.
module prog_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [14:0] mem_wdata,
   output logic        cpu_reset_n,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_DONE
   } state_t;

   state_t     state, state_nx;
   logic [8:0] n_words;
   logic [8:0] word_cnt;
   logic       last_word;

   assign last_word = (word_cnt + 9'd1) == n_words;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nx = S_COUNT;
         end
         S_COUNT: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_HI;
         end
         S_HI: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = in_data[7] ? S_IDLE : S_LO;
         end
         S_LO: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = S_WRITE;
         end
         S_WRITE: begin
            mem_we   = 1'b1;
            state_nx = last_word ? S_DONE : S_HI;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // in_ready is 1 in COUNT/HI/LO, so in_valid alone marks a transfer there.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_words     <= 9'd0;
         word_cnt    <= 9'd0;
         mem_addr    <= 8'd0;
         mem_wdata   <= 15'd0;
         cpu_reset_n <= 1'b0;
         err         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cpu_reset_n <= 1'b0;
                  err         <= 1'b0;
                  mem_addr    <= 8'd0;
                  word_cnt    <= 9'd0;
               end
            end
            S_COUNT: begin
               if (in_valid) n_words <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end
            S_HI: begin
               if (in_valid) begin
                  if (in_data[7]) err <= 1'b1;
                  else            mem_wdata[14:8] <= in_data[6:0];
               end
            end
            S_LO: begin
               if (in_valid) mem_wdata[7:0] <= in_data;
            end
            S_WRITE: begin
               word_cnt <= word_cnt + 9'd1;
               if (!last_word) mem_addr <= mem_addr + 8'd1;
            end
            S_DONE: cpu_reset_n <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [14:0] mem_wdata;
   logic        cpu_reset_n;
   logic        busy;
   logic        done;
   logic        err;

   int n_total = 0;
   int n_bad   = 0;
   logic [7:0] stream[$];

   prog_loader dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_reset_n (cpu_reset_n),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drives the stream in `stream` through one session and checks every cycle against
   // expectations derived from the byte positions in the stream.
   // poke: 0 none, 1 start during WRITE cycles, 2 random start while busy.
   task automatic run_session(input int stall_pct, input int gap, input int poke, input bit partial);
      int n, nw, last, idx, cyc, dones, writes, gap_left;
      bit bad_frame, xfer, lo_now;
      logic [7:0]  exp_a;
      logic [14:0] exp_d;
      n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
      nw = n;
      bad_frame = 1'b0;
      for (int w = 0; w < n; w++) begin
         if (1 + 2*w < stream.size() && stream[1 + 2*w][7]) begin
            nw = w;
            bad_frame = 1'b1;
            break;
         end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_cpu", cpu_reset_n, 0);
      chk("start_err", err, 0);
      chk("start_addr", mem_addr, 0);
      idx = 0; dones = 0; writes = 0; gap_left = 0;
      for (cyc = 0; cyc < 6000; cyc++) begin
         in_valid = (idx < stream.size()) && (gap_left == 0) && ($urandom_range(99) >= stall_pct);
         in_data  = in_valid ? stream[idx] : 8'($urandom);
         start    = (poke == 2) ? ($urandom_range(3) == 0) : (poke == 1 && mem_we);
         if (gap_left > 0) gap_left--;
         xfer   = in_valid && in_ready;
         lo_now = xfer && idx >= 2 && (idx % 2 == 0);
         exp_a  = 8'((idx - 2) / 2);
         exp_d  = (idx >= 2) ? {stream[idx-1][6:0], stream[idx]} : 15'd0;
         @(posedge clk); #1;
         chk("mem_we", mem_we, lo_now);
         if (lo_now) begin
            chk("wr_addr", mem_addr, exp_a);
            chk("wr_data", mem_wdata, exp_d);
         end
         if (xfer) begin
            if (idx % 2 == 1) gap_left = gap;
            idx++;
         end
         if (done) dones++;
         if (mem_we) writes++;
         if (partial && idx == stream.size()) break;
         if (!busy) break;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (partial) begin
         chk("partial_idx", idx, stream.size());
      end else begin
         chk("end_busy", busy, 0);
         chk("writes", writes, nw);
         chk("dones", dones, bad_frame ? 0 : 1);
         chk("end_err", err, bad_frame);
         chk("end_cpu", cpu_reset_n, !bad_frame);
         chk("end_addr", mem_addr, bad_frame ? nw % 256 : (n - 1) % 256);
         last = bad_frame ? nw - 1 : n - 1;
         if (last >= 0) chk("end_wdata", mem_wdata, {stream[1+2*last][6:0], stream[2+2*last]});
         repeat (2) begin
            @(posedge clk); #1;
            chk("idle_we", mem_we, 0);
            chk("idle_ready", in_ready, 0);
         end
      end
   endtask

   task automatic set_nominal();
      stream = {8'h03, 8'h40, 8'h00, 8'h33, 8'h01, 8'h41, 8'h00};
   endtask

   initial begin
      int n, errw;
      logic [7:0] hb;
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_cpu", cpu_reset_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      set_nominal();
      run_session(0, 0, 0, 1'b0);
      set_nominal();
      run_session(0, 5, 0, 1'b0);

      stream = {8'h02, 8'h40, 8'h00, 8'h80};
      run_session(0, 0, 0, 1'b0);
      set_nominal();
      run_session(10, 0, 0, 1'b0);

      stream = {8'h00};
      for (int i = 0; i < 256; i++) begin
         stream.push_back(8'h00);
         stream.push_back(8'(i));
      end
      run_session(0, 0, 0, 1'b0);

      stream = {8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
      run_session(0, 0, 1, 1'b0);

      stream = {8'h02, 8'h40, 8'h00, 8'h33};
      run_session(0, 0, 0, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("abort_ready", in_ready, 0);
      chk("abort_we", mem_we, 0);
      chk("abort_addr", mem_addr, 0);
      chk("abort_wdata", mem_wdata, 0);
      chk("abort_cpu", cpu_reset_n, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_err", err, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (5) begin
         in_valid = 1'b1;
         in_data  = 8'h01;
         @(posedge clk); #1;
         chk("post_abort_we", mem_we, 0);
         chk("post_abort_busy", busy, 0);
         chk("post_abort_cpu", cpu_reset_n, 0);
      end
      in_valid = 1'b0;

      for (int s = 0; s < 25; s++) begin
         n = $urandom_range(1, 6);
         errw = ($urandom_range(3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         stream = {8'(n)};
         for (int w = 0; w < n; w++) begin
            hb = 8'($urandom) & 8'h7f;
            if (w == errw) begin
               stream.push_back(hb | 8'h80);
               break;
            end
            stream.push_back(hb);
            stream.push_back(8'($urandom));
         end
         run_session($urandom_range(0, 40), $urandom_range(0, 3), 2, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; clears all state immediately.
REQ-003 start  input  1  one-cycle request to begin a load session; honoured only in IDLE.
REQ-004 in_data  input  8  incoming byte stream.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_ready  output  1  loader can accept a byte; a byte transfers on a cycle with in_valid=1 and in_ready=1.
REQ-007 mem_we  output  1  one-cycle write strobe to the writable instruction memory.
REQ-008 mem_addr  output  8  instruction memory write address.
REQ-009 mem_wdata  output  15  instruction word to write.
REQ-010 cpu_reset_n  output  1  active-low reset to the CPU core; low holds the CPU stopped.
REQ-011 busy  output  1  session in progress (any state other than IDLE).
REQ-012 done  output  1  one-cycle pulse on successful session completion.
REQ-013 err  output  1  sticky framing-error flag.

Function
REQ-014 The FSM SHALL have the states IDLE, COUNT, HI, LO, WRITE and DONE.
REQ-015 IDLE -> COUNT on start=1: in the same edge, cpu_reset_n goes 0, err clears and mem_addr clears to 0.
REQ-016 in_ready SHALL be 1 only in COUNT, HI and LO, and 0 in IDLE, WRITE and DONE.
REQ-017 COUNT: on transfer, latch N=in_data as the word count (0 means 256 words), then go to HI.
REQ-018 HI: on transfer, if in_data[7]=1, set err=1 and go to IDLE with no write and cpu_reset_n kept 0.
REQ-019 HI: on transfer, if in_data[7]=0, latch in_data[6:0] into mem_wdata[14:8] and go to LO.
REQ-020 LO: on transfer, latch in_data into mem_wdata[7:0] and go to WRITE.
REQ-021 WRITE lasts exactly one cycle with mem_we=1, mem_addr = current word index and mem_wdata = the assembled word. mem_we SHALL be 0 in every other state.
REQ-022 Write latency: mem_we asserts in the cycle immediately after the LO byte transfer.
REQ-023 WRITE exit: if the word just written was the Nth word, go to DONE; otherwise increment mem_addr (8-bit) and go to HI.
REQ-024 For N=0 (256 words), 256 writes SHALL cover addresses 0..255. mem_addr SHALL NOT wrap or increment after the final write.
REQ-025 The word counter SHALL be 9 bits wide so that 256 is representable.
REQ-026 DONE lasts one cycle with done=1, then the FSM goes to IDLE; cpu_reset_n goes 1 on the same edge that leaves DONE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 In HI/LO, cycles with in_valid=0 hold state and data (stalls of any length are allowed).
REQ-029 mem_addr and mem_wdata SHALL hold their last values while idle.
REQ-030 After an error, cpu_reset_n stays 0 until a later session completes successfully.

Reset
REQ-031 reset=0 SHALL force: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, busy=0, done=0, err=0, N=0, word counter=0.
REQ-032 A reset asserted mid-session SHALL abort the session with no further mem_we, and the CPU SHALL remain held (cpu_reset_n=0).

Verification
REQ-033 Nominal: start, bytes 03, 40,00, 33,01, 41,00 with in_valid held high -> writes (0,0x4000), (1,0x3301), (2,0x4100).
- Each mem_we is one cycle after its LO byte.
- done pulses once, then cpu_reset_n=1 and busy=0.
REQ-034 Stall: same stream with in_valid dropped for 5 cycles between each HI and LO byte -> identical writes, and no mem_we during the stalls.
REQ-035 Framing error: start, 02, 40,00, then 80 -> exactly one write (0,0x4000), then err=1, busy=0 and cpu_reset_n=0.
- A following successful session clears err and releases the CPU.
REQ-036 Max length: start, 00, then 256 words whose value equals the index -> addresses 0..255 each written once, mem_addr ends at 0xFF, done pulses exactly once.
REQ-037 Reset abort: assert reset after the HI byte of word 1 -> all outputs take their REQ-031 values immediately, no further writes occur, and a start pulse during the reset low period has no effect.
REQ-038 Ignored start: pulse start during WRITE of a 2-word session -> session completes unchanged with exactly 2 writes.
